// File: rtl/mbc_dance_seq_pkg.sv
// Shared types and default constants for the MBC boot-handshake ("dance") sequencer.
package mbc_dance_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dance_state_t;

    localparam int          DEF_PATTERN_LEN  = 21;
    localparam logic [20:0] DEF_PATTERN      = 21'h28A07;
    localparam logic [7:0]  DEF_TRIG_LO      = 8'h05;
    localparam logic [7:0]  DEF_TRIG_LO_MASK = 8'h0F;
    localparam logic [3:0]  DEF_TRIG_HI      = 4'hA;

    // Counter width for a count range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mbc_dance_seq.sv
// Serial boot-handshake generator: waits for a trigger address, then shifts
// PATTERN out on MBC (LSB first, BIT_CYCLES clocks per bit) and reports Busy/Done.
module mbc_dance_seq
    import mbc_dance_seq_pkg::*;
#(
    parameter int                     PATTERN_LEN  = DEF_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN      = DEF_PATTERN,
    parameter logic                   IDLE_LEVEL   = 1'b1,
    parameter int                     BIT_CYCLES   = 1,
    parameter logic [7:0]             TRIG_LO      = DEF_TRIG_LO,
    parameter logic [7:0]             TRIG_LO_MASK = DEF_TRIG_LO_MASK,
    parameter logic [3:0]             TRIG_HI      = DEF_TRIG_HI,
    parameter bit                     ONE_SHOT     = 1'b1
) (
    input  logic       SClk,
    input  logic       nReset,
    input  logic [7:0] AddrLo,
    input  logic [3:0] AddrHi,
    input  logic       Enable,
    output logic       MBC,
    output logic       Busy,
    output logic       Done
);

    localparam int BW = cnt_w(PATTERN_LEN);
    localparam int CW = cnt_w(BIT_CYCLES);
    localparam int PW = 1 << BW;

    localparam logic [BW-1:0] BIT_LAST = BW'(PATTERN_LEN - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    // Padded to the full index range so any bit-counter value selects safely.
    localparam logic [PW-1:0] PAT_EXT  = PW'(PATTERN);

    dance_state_t  state, state_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic          mbc_nxt, busy_nxt, done_nxt;
    logic          trig;

    assign trig = ((AddrLo & TRIG_LO_MASK) == (TRIG_LO & TRIG_LO_MASK))
                  && (AddrHi == TRIG_HI) && Enable;

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        cyc_nxt   = cyc_cnt;
        mbc_nxt   = IDLE_LEVEL;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_nxt = ST_RUN;
                    bit_nxt   = '0;
                    cyc_nxt   = '0;
                    mbc_nxt   = PAT_EXT[0];
                    busy_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (cyc_cnt == CYC_LAST) begin
                    cyc_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = ST_DONE;
                        bit_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_nxt  = bit_cnt + 1'b1;
                        mbc_nxt  = PAT_EXT[bit_nxt];
                        busy_nxt = 1'b1;
                    end
                end else begin
                    cyc_nxt  = cyc_cnt + 1'b1;
                    mbc_nxt  = PAT_EXT[bit_cnt];
                    busy_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                // One-shot parts park here until reset; re-armable parts pulse Done once.
                if (ONE_SHOT) begin
                    done_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            MBC     <= IDLE_LEVEL;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            cyc_cnt <= cyc_nxt;
            MBC     <= mbc_nxt;
            Busy    <= busy_nxt;
            Done    <= done_nxt;
        end
    end

endmodule
